// File: rtl/fir_ss_feeder.sv
// fir_ss_feeder: streams x[n] samples from the sample BRAM onto the FIR AXI-Stream input through a 2-entry prefetch FIFO
module fir_ss_feeder #(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int pLEN_WIDTH  = 11
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   start,
   input  logic [pLEN_WIDTH-1:0]  data_length,
   input  logic [pADDR_WIDTH-1:0] base_addr,
   output logic                   busy,
   output logic                   done,
   output logic [pLEN_WIDTH-1:0]  sample_cnt,
   output logic                   src_EN,
   output logic [pADDR_WIDTH-1:0] src_A,
   input  logic [pDATA_WIDTH-1:0] src_Do,
   output logic                   ss_tvalid,
   output logic [pDATA_WIDTH-1:0] ss_tdata,
   output logic                   ss_tlast,
   input  logic                   ss_tready
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [pLEN_WIDTH-1:0] LEN_ONE = 1;
   state_t                 state_q, state_d;
   logic [pLEN_WIDTH-1:0]  len_q, len_d, rd_ptr_q, rd_ptr_d, sample_cnt_q, sample_cnt_d;
   logic [pADDR_WIDTH-1:0] base_q, base_d, src_a_q, src_a_d;
   logic [pDATA_WIDTH-1:0] mem_q [2];
   logic [pDATA_WIDTH-1:0] mem_d [2];
   logic [1:0]             last_q, last_d, occ_q, occ_d;
   logic                   rptr_q, rptr_d, wptr_q, wptr_d;
   logic                   infl_q, infl_d, infl_last_q, infl_last_d;
   logic [2:0]             load;
   logic                   issue, pop, push;

   // A read may issue only if FIFO entries plus the in-flight read, less this cycle's pop, leave room for it
   always_comb begin
      pop   = ss_tvalid & ss_tready;
      push  = infl_q;
      load  = {1'b0, occ_q} + {2'b00, infl_q};
      issue = (state_q == RUN) && (rd_ptr_q < len_q) && ((load < 3'd2) || (pop && load == 3'd2));
   end

   // Next-state for control, read pointer, FIFO and beat counter
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      base_d       = base_q;
      rd_ptr_d     = issue ? rd_ptr_q + LEN_ONE : rd_ptr_q;
      sample_cnt_d = pop ? sample_cnt_q + LEN_ONE : sample_cnt_q;
      src_a_d      = issue ? base_q + pADDR_WIDTH'({rd_ptr_q, 2'b00}) : src_a_q;
      infl_d       = issue;
      infl_last_d  = issue && (rd_ptr_q + LEN_ONE == len_q);
      mem_d        = mem_q;
      last_d       = last_q;
      if (push) begin
         mem_d[wptr_q]  = src_Do;
         last_d[wptr_q] = infl_last_q;
      end
      wptr_d = wptr_q ^ push;
      rptr_d = rptr_q ^ pop;
      occ_d  = occ_q + {1'b0, push} - {1'b0, pop};
      case (state_q)
         IDLE: if (start) begin
            len_d        = data_length;
            base_d       = base_addr;
            rd_ptr_d     = '0;
            sample_cnt_d = '0;
            state_d      = (data_length != '0) ? RUN : DONE;
         end
         RUN: if (pop && ss_tlast) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Registers; asynchronous reset flushes the FIFO and any in-flight read
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q      <= IDLE;
         len_q        <= '0;
         base_q       <= '0;
         rd_ptr_q     <= '0;
         sample_cnt_q <= '0;
         src_a_q      <= '0;
         mem_q        <= '{default: '0};
         last_q       <= '0;
         occ_q        <= '0;
         rptr_q       <= 1'b0;
         wptr_q       <= 1'b0;
         infl_q       <= 1'b0;
         infl_last_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_q        <= len_d;
         base_q       <= base_d;
         rd_ptr_q     <= rd_ptr_d;
         sample_cnt_q <= sample_cnt_d;
         src_a_q      <= src_a_d;
         mem_q        <= mem_d;
         last_q       <= last_d;
         occ_q        <= occ_d;
         rptr_q       <= rptr_d;
         wptr_q       <= wptr_d;
         infl_q       <= infl_d;
         infl_last_q  <= infl_last_d;
      end
   end

   assign busy       = state_q != IDLE;
   assign done       = state_q == DONE;
   assign sample_cnt = sample_cnt_q;
   assign src_EN     = issue;
   assign src_A      = src_a_d;
   assign ss_tvalid  = occ_q != 2'd0;
   assign ss_tdata   = ss_tvalid ? mem_q[rptr_q] : '0;
   assign ss_tlast   = ss_tvalid & last_q[rptr_q];
endmodule

// File: doc/fir_ss_feeder.md
Name: fir_ss_feeder

Overview:
- Upstream stage of the FIR core: reads x[n] samples from a sample BRAM and drives them on the FIR AXI-Stream input (ss_tvalid/ss_tdata/ss_tlast/ss_tready).
- Started by a one-cycle start pulse with a programmed sample count.
- Asserts ss_tlast on the final sample and pulses done once the last beat is accepted.
- Internal 2-entry prefetch FIFO hides the 1-cycle BRAM read latency and sustains one beat per cycle under full backpressure-free flow.

Parameters:
pADDR_WIDTH, 12, sample BRAM byte-address width
pDATA_WIDTH, 32, sample width
pLEN_WIDTH, 11, width of sample-count register (max 2047 samples)

Ports:
axis_clk  input  1  clock
axis_rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle start pulse; honoured only in IDLE
data_length  input  pLEN_WIDTH  number of samples to send; sampled on accepted start
base_addr  input  pADDR_WIDTH  byte address of sample 0; sampled on accepted start
busy  output  1  high from accepted start until done pulse (inclusive)
done  output  1  one-cycle pulse after final beat accepted
sample_cnt  output  pLEN_WIDTH  beats accepted downstream in current run
src_EN  output  1  BRAM read enable
src_A  output  pADDR_WIDTH  BRAM byte read address
src_Do  input  pDATA_WIDTH  BRAM read data, valid the cycle after src_EN/src_A
ss_tvalid  output  1  stream valid to FIR
ss_tdata  output  pDATA_WIDTH  stream data
ss_tlast  output  1  high with the final sample
ss_tready  input  1  FIR ready

Behaviour:
- Reset (async, any time incl. mid-run): state IDLE, FIFO and in-flight read flushed; busy, done, src_EN, ss_tvalid, ss_tlast = 0; ss_tdata, src_A, sample_cnt = 0. No beat is emitted after reset deasserts until a new start.
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches len=data_length, base=base_addr; rd_ptr=0, sample_cnt=0.
  - len != 0 -> RUN.
  - len == 0 -> DONE directly; no stream beats, no BRAM reads.
- RUN:
  - Read issue: src_EN=1, src_A=base+4*rd_ptr (mod 2^pADDR_WIDTH, wraps silently) when rd_ptr<len AND (fifo_occ + inflight - pop) < 2, where pop = ss_tvalid & ss_tready this cycle; rd_ptr increments on issue.
  - src_EN=0 otherwise; src_A holds its last value.
  - Read data src_Do is written into FIFO on the edge following the issue cycle.
  - ss_tvalid = FIFO non-empty; ss_tdata = FIFO head; ss_tlast = 1 iff head is sample index len-1.
  - Once ss_tvalid=1, ss_tvalid/ss_tdata/ss_tlast are held stable until ss_tready=1.
  - Beat accepted when ss_tvalid & ss_tready; sample_cnt increments by 1.
  - Simultaneous FIFO push and pop: occupancy unchanged, order preserved.
  - Accepting the beat with ss_tlast=1 -> DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE. sample_cnt holds its final value until the next accepted start.
- start while busy (RUN or DONE) is ignored; data_length and base_addr are not re-sampled.
- Latency: start high in cycle 0 -> first src_EN in cycle 1 -> ss_tvalid first high in cycle 3.
- Throughput: with ss_tready held at 1, one beat per cycle with no bubbles after the first beat. Last beat accepted in cycle len+2; done in cycle len+3.
- Backpressure: with ss_tready=0, at most 2 samples are buffered (FIFO plus in-flight read), no read is issued that would overflow, and no sample is dropped or duplicated.
- FIFO never overflows; popping from an empty FIFO cannot occur because ss_tvalid=0 when empty.

Test Plan:
1. len=11, base=0, BRAM[i]=i+1, ss_tready=1 -> beats 1..11 on consecutive cycles 3..13; tlast only on 11; done pulse at cycle 14; sample_cnt=11.
2. len=5, ss_tready toggling 1,0,0,1,... -> exactly 5 beats in order; tdata/tlast stable while stalled; no src_EN while fifo_occ+inflight=2.
3. len=0 start -> done pulse next cycle; ss_tvalid and src_EN never asserted.
4. len=600, base=0xFFC (12-bit) -> first src_A=0xFFC, second=0x000 (wrap); 600 beats, tlast on the 600th.
5. start pulse during RUN with different data_length -> ignored; the original run completes with its original length.
6. axis_rst_n dropped after 3 beats of len=10 -> all outputs 0 immediately; after release no beats; a new start with len=2 emits exactly 2 beats with tlast on the 2nd.
